// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped buffered UART transmitter (8N1).
// CPU stores to TXDATA queue a byte in a FIFO; the TX FSM drains the FIFO
// and serialises each byte LSB first. CPU loads of STATUS return fill level
// and flags so firmware can poll.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           decode select for this block's address window
//   load_enable  CPU load in progress
//   store_enable CPU store in progress
//   reg_sel      0 = TXDATA, 1 = STATUS
//   data_in      store data, [7:0] used
//   data_out     combinational read data (STATUS only, else 0)
//   txd          UART serial output, idle high
//   irq_empty    registered: FIFO empty and transmitter idle
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_enable,
  input  logic        store_enable,
  input  logic        reg_sel,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        txd,
  output logic        irq_empty
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int unsigned   CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL    = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wr_prev_q;
  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          irq_q, irq_d;

  logic wr_cond, wr_edge, push_req, ovf_clr, push, pop, empty, full, busy;
  logic unused_data;

  assign unused_data = ^data_in[31:8];

  // Only the first cycle of a (possibly multi-cycle) store acts.
  assign wr_cond  = en & store_enable;
  assign wr_edge  = wr_cond & ~wr_prev_q;
  assign push_req = wr_edge & ~reg_sel;
  assign ovf_clr  = wr_edge & reg_sel;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign busy  = (state_q != IDLE);
  assign pop   = (state_q == IDLE) & ~empty;
  // Fullness is judged before any same-cycle pop.
  assign push  = push_req & ~full;

  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q;
    if (push & ~pop)
      count_d = count_q + (AW+1)'(1);
    else if (pop & ~push)
      count_d = count_q - (AW+1)'(1);
    ovf_d = ovf_q;
    if (push_req & full)
      ovf_d = 1'b1;
    else if (ovf_clr)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= data_in[7:0];
  end

  // FSM process 1: state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      wr_prev_q <= 1'b0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b1;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      wr_prev_q <= wr_cond;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
    end
  end

  // FSM process 2: next state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rptr_q];
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = STOP;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0)
          state_d = IDLE;
        else
          baud_d = baud_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM process 3: outputs. txd is decoded from the next state and then
  // registered, so the line is glitch-free yet changes in the same cycle
  // the state does.
  always_comb begin
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    irq_d = empty & (state_q == IDLE);
  end

  always_comb begin
    data_out = '0;
    if (en & load_enable & reg_sel) begin
      data_out[8 +: AW+1] = count_q;
      data_out[3]         = ovf_q;
      data_out[2]         = full;
      data_out[1]         = empty;
      data_out[0]         = busy;
    end
  end

  assign txd       = txd_q;
  assign irq_empty = irq_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst, en, load_enable, store_enable, reg_sel;
  logic [31:0] data_in, data_out;
  logic        txd, irq_empty;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .load_enable(load_enable),
    .store_enable(store_enable), .reg_sel(reg_sel), .data_in(data_in),
    .data_out(data_out), .txd(txd), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, sticky overflow, and the position inside
  // the current frame (-1 when idle). txd is derived from frame position.
  logic [7:0] mq[$];
  logic       m_ovf, m_irq, m_prev;
  int         m_ft;
  logic [7:0] m_byte;

  function automatic void model_update();
    logic wr, edg, was_full, do_pop;
    if (rst) begin
      mq.delete(); m_ovf = 1'b0; m_ft = -1; m_irq = 1'b1; m_prev = 1'b0;
      return;
    end
    wr = en & store_enable;
    edg = wr & ~m_prev;
    m_prev = wr;
    was_full = (mq.size() == DEPTH);
    m_irq = (mq.size() == 0) && (m_ft < 0);
    do_pop = (m_ft < 0) && (mq.size() > 0);
    if (m_ft >= 0) begin
      m_ft++;
      if (m_ft == FRAME) m_ft = -1;
    end else if (do_pop) begin
      m_byte = mq.pop_front();
      m_ft = 0;
    end
    if (edg && !reg_sel) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(data_in[7:0]);
    end
    if (edg && reg_sel) m_ovf = 1'b0;
  endfunction

  function automatic logic exp_txd();
    int idx;
    if (m_ft < 0) return 1'b1;
    idx = m_ft / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[12:8] = 5'(mq.size());
    s[3] = m_ovf;
    s[2] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[0] = (m_ft >= 0);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic peek_status(output logic [31:0] v);
    logic e, l, s, r;
    e = en; l = load_enable; s = store_enable; r = reg_sel;
    en = 1'b1; load_enable = 1'b1; store_enable = 1'b0; reg_sel = 1'b1;
    #1 v = data_out;
    en = e; load_enable = l; store_enable = s; reg_sel = r;
  endtask

  task automatic do_reset();
    en = 0; load_enable = 0; store_enable = 0; reg_sel = 0; data_in = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] st;
    do_reset();
    peek_status(st);
    checks += 5;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
    if (irq_empty !== 1'b1) begin errors++; $display("FAIL reset_irq got=%b exp=1", irq_empty); end
    if (st !== 32'h0000_0002) begin errors++; $display("FAIL reset_status got=%h exp=00000002", st); end
    en = 1'b0; load_enable = 1'b1; reg_sel = 1'b1; #1;
    if (data_out !== 32'h0) begin errors++; $display("FAIL read_en0 got=%h exp=0", data_out); end
    en = 1'b1; reg_sel = 1'b0; #1;
    if (data_out !== 32'h0) begin errors++; $display("FAIL read_txdata got=%h exp=0", data_out); end
    en = 1'b0; load_enable = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] st;
    logic [7:0]  rx;
    int          first_low, k;
    do_reset();
    en = 1; store_enable = 1; reg_sel = 0; data_in = 32'hFFFF_FFA5;
    tick();
    en = 0; store_enable = 0; data_in = '0;
    first_low = -1; rx = '0;
    for (int cyc = 1; cyc <= 46; cyc++) begin
      peek_status(st);
      checks += 3;
      if (txd !== exp_txd()) begin errors++; $display("FAIL single_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      if (irq_empty !== m_irq) begin errors++; $display("FAIL single_irq cyc=%0d got=%b exp=%b", cyc, irq_empty, m_irq); end
      if (st !== exp_status()) begin errors++; $display("FAIL single_status cyc=%0d got=%h exp=%h", cyc, st, exp_status()); end
      if (txd === 1'b0 && first_low < 0) first_low = cyc;
      if (cyc >= 2 && (cyc - 2) % CPB == 1) begin
        k = (cyc - 2) / CPB;
        if (k >= 1 && k <= 8) rx[k-1] = txd;
      end
      tick();
    end
    checks += 3;
    if (first_low !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", first_low); end
    if (rx !== 8'hA5) begin errors++; $display("FAIL single_rxbyte got=%h exp=a5", rx); end
    if (irq_empty !== 1'b1) begin errors++; $display("FAIL single_irq_end got=%b exp=1", irq_empty); end
  endtask

  task automatic test_held();
    logic [31:0] st;
    int          maxc;
    do_reset();
    maxc = 0;
    en = 1; store_enable = 1; reg_sel = 0; data_in = 32'h0000_003C;
    for (int cyc = 0; cyc < 55; cyc++) begin
      if (cyc == 5) begin en = 0; store_enable = 0; end
      tick();
      peek_status(st);
      checks += 3;
      if (txd !== exp_txd()) begin errors++; $display("FAIL held_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      if (irq_empty !== m_irq) begin errors++; $display("FAIL held_irq cyc=%0d got=%b exp=%b", cyc, irq_empty, m_irq); end
      if (st !== exp_status()) begin errors++; $display("FAIL held_status cyc=%0d got=%h exp=%h", cyc, st, exp_status()); end
      if (int'(st[12:8]) > maxc) maxc = int'(st[12:8]);
    end
    checks++;
    if (maxc > 1) begin errors++; $display("FAIL held_maxcount got=%0d exp<=1", maxc); end
  endtask

  task automatic test_overflow();
    logic [31:0] st;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        en = (ph == 0); store_enable = (ph == 0); reg_sel = 0; data_in = 32'(k);
        tick();
        peek_status(st);
        checks += 2;
        if (txd !== exp_txd()) begin errors++; $display("FAIL ovf_txd k=%0d got=%b exp=%b", k, txd, exp_txd()); end
        if (st !== exp_status()) begin errors++; $display("FAIL ovf_status k=%0d got=%h exp=%h", k, st, exp_status()); end
      end
    end
    checks++;
    if (st !== 32'h0000_100D) begin errors++; $display("FAIL ovf_full_status got=%h exp=0000100d", st); end
    en = 1; store_enable = 1; reg_sel = 1;
    tick();
    en = 0; store_enable = 0; reg_sel = 0;
    peek_status(st);
    checks++;
    if (st[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", st[3]); end
    for (int cyc = 0; cyc < 17 * (FRAME + 1) + 10; cyc++) begin
      tick();
      peek_status(st);
      checks += 3;
      if (txd !== exp_txd()) begin errors++; $display("FAIL drain_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      if (irq_empty !== m_irq) begin errors++; $display("FAIL drain_irq cyc=%0d got=%b exp=%b", cyc, irq_empty, m_irq); end
      if (st !== exp_status()) begin errors++; $display("FAIL drain_status cyc=%0d got=%h exp=%h", cyc, st, exp_status()); end
    end
    checks++;
    if (m_byte !== 8'h10) begin errors++; $display("FAIL drain_last_model got=%h exp=10", m_byte); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] st;
    bit          hit;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        en = (ph == 0); store_enable = (ph == 0); reg_sel = 0; data_in = $urandom;
        tick();
        peek_status(st);
        checks++;
        if (st !== exp_status()) begin errors++; $display("FAIL ppf_fill k=%0d got=%h exp=%h", k, st, exp_status()); end
      end
    end
    hit = 1'b0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      if (m_ft < 0 && mq.size() == DEPTH) begin
        hit = 1'b1;
      end else begin
        tick();
        checks++;
        if (txd !== exp_txd()) begin errors++; $display("FAIL ppf_wait_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL ppf_timeout got=no_idle_full exp=idle_full"); end
    en = 1; store_enable = 1; reg_sel = 0; data_in = $urandom;
    tick();
    en = 0; store_enable = 0;
    peek_status(st);
    checks += 2;
    if (st !== 32'h0000_0F09) begin errors++; $display("FAIL ppf_status got=%h exp=00000f09", st); end
    if (st !== exp_status()) begin errors++; $display("FAIL ppf_model got=%h exp=%h", st, exp_status()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] st;
    bit          hit;
    hit = 1'b0;
    for (int cyc = 0; cyc < 3 * FRAME && !hit; cyc++) begin
      if (m_ft == 4 * CPB + 1) hit = 1'b1;
      else tick();
    end
    checks += 2;
    if (!hit) begin errors++; $display("FAIL rstmid_timeout got=no_bit3 exp=bit3"); end
    if (mq.size() < 3) begin errors++; $display("FAIL rstmid_queued got=%0d exp>=3", mq.size()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peek_status(st);
    checks += 2;
    if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd got=%b exp=1", txd); end
    if (st !== 32'h0000_0002) begin errors++; $display("FAIL rstmid_status got=%h exp=00000002", st); end
    for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
      tick();
      peek_status(st);
      checks += 2;
      if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_quiet cyc=%0d got=%b exp=1", cyc, txd); end
      if (st !== 32'h0000_0002) begin errors++; $display("FAIL rstmid_quiet_status cyc=%0d got=%h exp=00000002", cyc, st); end
    end
  endtask

  task automatic test_random();
    logic [31:0] st, exp_rd;
    do_reset();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      en = ($urandom_range(0, 3) != 0);
      store_enable = ($urandom_range(0, 2) == 0);
      load_enable = $urandom_range(0, 1);
      reg_sel = ($urandom_range(0, 7) == 0);
      data_in = $urandom;
      tick();
      exp_rd = (en && load_enable && reg_sel) ? exp_status() : 32'h0;
      checks++;
      if (data_out !== exp_rd) begin errors++; $display("FAIL rand_read cyc=%0d got=%h exp=%h", cyc, data_out, exp_rd); end
      peek_status(st);
      checks += 3;
      if (txd !== exp_txd()) begin errors++; $display("FAIL rand_txd cyc=%0d got=%b exp=%b", cyc, txd, exp_txd()); end
      if (irq_empty !== m_irq) begin errors++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", cyc, irq_empty, m_irq); end
      if (st !== exp_status()) begin errors++; $display("FAIL rand_status cyc=%0d got=%h exp=%h", cyc, st, exp_status()); end
    end
  endtask

  initial begin
    rst = 1; en = 0; load_enable = 0; store_enable = 0; reg_sel = 0; data_in = '0;
    m_ft = -1; m_ovf = 0; m_irq = 1; m_prev = 0; m_byte = '0;
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
